change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Parametrised successor to the vending machine's change-making block. It pays out a change amount one coin per handshake, always choosing the largest coin that fits, from N denominations. It keeps a per-denomination coin inventory, which a refill port reloads, in place of plain availability flags. Output is flow-controlled by valid/ready, and each transaction closes with a completion pulse that reports any unpaid shortfall.

Parameters:
AMT_W, 9, width of change amount and denomination values (cents)
NUM_COINS, 5, number of denominations
CNT_W, 4, width of each inventory counter (max 2^CNT_W-1 coins)
COIN_VALUES, {9'd100,9'd50,9'd25,9'd10,9'd5}, packed NUM_COINS*AMT_W vector; slice i = value of coin i; index 0 smallest; values strictly increasing with index and nonzero

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  change request valid
req_ready  out  1  block can accept a request (high only in IDLE)
req_amount  in  AMT_W  change to pay, cents
coin_valid  out  1  coin_onehot holds a coin to dispense
coin_ready  in  1  dispenser mechanism accepts the coin
coin_onehot  out  NUM_COINS  one-hot coin select; bit i = coin i
refill_en  in  1  add coins to inventory this cycle
refill_idx  in  $clog2(NUM_COINS)  denomination to refill
refill_cnt  in  CNT_W  coins added
inv_empty  out  NUM_COINS  bit i high when inventory[i]==0
done  out  1  one-cycle pulse: transaction complete
shortfall  out  AMT_W  unpaid remainder, valid with done, held until next done
paid  out  AMT_W  amount actually dispensed, valid with done, held until next done

Behaviour:
- Reset (reset_n low, async): state=IDLE; rem=0; coin_valid=0; coin_onehot=0; done=0; shortfall=0; paid=0; all inventory counters=0 (inv_empty all ones). req_ready=1 once reset deasserts.
- Clock and reset ports are named clk and reset_n. The reset is asynchronous and active-low, and the block runs on one clock.
- Outputs are registered, except req_ready, which is decoded from state.
- States: IDLE, SELECT, DISPENSE, DONE.
- IDLE: req_ready=1. On req_valid, latch rem=req_amount and paid_acc=0, then go to SELECT.
- SELECT (one cycle): if rem==0, go to DONE with shortfall=0. Otherwise pick the highest i with COIN_VALUES[i]<=rem and inventory[i]>0.
  - Coin found: coin_onehot<=1<<i, coin_valid<=1, go to DISPENSE.
  - No coin: shortfall<=rem, go to DONE (remainder is kept by the machine).
- DISPENSE: hold coin_valid and coin_onehot stable until coin_ready. On the handshake cycle:
  - rem-=value, paid_acc+=value, inventory[i]-=1
  - coin_valid<=0, coin_onehot<=0, go to SELECT.
  - No upper limit on the stall.
- DONE (one cycle): done=1, paid=paid_acc, shortfall already set, then go to IDLE.
- Latency, request to first coin_valid: 2 cycles (accept, SELECT). Per coin with coin_ready held high: 2 cycles (DISPENSE, SELECT).
- Refill: accepted in any state, including IDLE.
  - inventory[refill_idx]+=refill_cnt, saturating at 2^CNT_W-1.
  - refill_idx>=NUM_COINS is ignored.
  - Refill and dispense decrement on the same index in the same cycle apply together: net = inv - 1 + cnt, saturated.
  - A refill applied in a cycle is visible to the following SELECT.
- Arithmetic: rem never underflows, because selection guarantees value<=rem. paid_acc+rem always equals req_amount.
- req_amount=0: go straight through SELECT to DONE with paid=0, shortfall=0.
- req_valid outside IDLE is ignored (req_ready=0).
- Reset mid-transaction: everything aborts. No done pulse. Inventory is cleared.

Decomposition:
- Package change_pkg holds:
  - state enum
  - default COIN_VALUES constant
  - one-hot bit-position constants (COIN_NICKEL..COIN_DOLLAR)
- Sub-module change_coin_select: combinational priority picker. Inputs rem, COIN_VALUES, and the inventory-nonzero vector. Outputs found and idx.

Test Plan:
- Full inventory (15 each), req 185, coin_ready=1 -> coins in order dollar, half, quarter, dime. done with paid=185, shortfall=0. Dollar inventory 15->14.
- Dollar inventory 0, others 15, req 185 -> half, half, half, quarter, dime. paid=185.
- Only nickels (2), req 17 -> nickel, nickel, then done with paid=10, shortfall=7.
- coin_ready held low 5 cycles on the first coin -> coin_valid and coin_onehot stable for all 5 cycles. Inventory decrements exactly once.
- Refill nickel count 3 in the same cycle as a nickel handshake, inventory 1 -> inventory 3. Refill count 15 onto 14 -> saturates at 15.
- reset_n low during DISPENSE -> coin_valid=0 immediately (async). No done pulse. req_ready=1 after release. inv_empty=all ones.

Source files
------------

// File: rtl/change_pkg.sv
// Shared types and constants for the change dispenser: FSM state encoding,
// the default US coin table and the bit position of each coin in coin_onehot.
package change_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StDispense,
    StDone
  } state_e;

  localparam int unsigned DEF_AMT_W     = 9;
  localparam int unsigned DEF_NUM_COINS = 5;

  // Slice i holds the value of coin i; index 0 is the smallest coin.
  localparam logic [DEF_NUM_COINS*DEF_AMT_W-1:0] DEF_COIN_VALUES =
      {9'd100, 9'd50, 9'd25, 9'd10, 9'd5};

  localparam int unsigned COIN_NICKEL  = 0;
  localparam int unsigned COIN_DIME    = 1;
  localparam int unsigned COIN_QUARTER = 2;
  localparam int unsigned COIN_HALF    = 3;
  localparam int unsigned COIN_DOLLAR  = 4;

endpackage

// File: rtl/change_coin_select.sv
// Combinational priority picker: finds the largest in-stock coin whose value
// does not exceed the remaining change.
module change_coin_select #(
  parameter int unsigned AMT_W     = 9,
  parameter int unsigned NUM_COINS = 5,
  parameter int unsigned IDX_W     = 3
) (
  input  logic [AMT_W-1:0]           i_rem,
  input  logic [NUM_COINS*AMT_W-1:0] i_coin_values,
  input  logic [NUM_COINS-1:0]       i_avail,
  output logic                       o_found,
  output logic [IDX_W-1:0]           o_idx
);

  // Ascending scan: the last match is the highest-valued eligible coin.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (i_avail[i] && (i_coin_values[i*AMT_W +: AMT_W] <= i_rem)) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount one coin per valid/ready handshake
// from a refillable per-denomination inventory and reports paid/shortfall.
module change_dispenser
  import change_pkg::*;
#(
  parameter int unsigned AMT_W     = 9,
  parameter int unsigned NUM_COINS = 5,
  parameter int unsigned CNT_W     = 4,
  parameter logic [NUM_COINS*AMT_W-1:0] COIN_VALUES = DEF_COIN_VALUES,
  localparam int unsigned IDX_W = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AMT_W-1:0]     req_amount,
  output logic                 coin_valid,
  input  logic                 coin_ready,
  output logic [NUM_COINS-1:0] coin_onehot,
  input  logic                 refill_en,
  input  logic [IDX_W-1:0]     refill_idx,
  input  logic [CNT_W-1:0]     refill_cnt,
  output logic [NUM_COINS-1:0] inv_empty,
  output logic                 done,
  output logic [AMT_W-1:0]     shortfall,
  output logic [AMT_W-1:0]     paid
);

  state_e               r_state, w_state_next;
  logic [AMT_W-1:0]     r_rem, w_rem_next;
  logic [AMT_W-1:0]     r_paid_acc, w_paid_acc_next;
  logic [AMT_W-1:0]     r_shortfall, w_shortfall_next;
  logic [AMT_W-1:0]     r_paid, w_paid_next;
  logic                 r_coin_valid, w_coin_valid_next;
  logic                 r_done, w_done_next;
  logic [NUM_COINS-1:0] r_coin_onehot, w_coin_onehot_next;
  logic [IDX_W-1:0]     r_coin_idx, w_coin_idx_next;
  logic [CNT_W-1:0]     r_inv [NUM_COINS];
  logic [CNT_W-1:0]     w_inv_next [NUM_COINS];
  logic [CNT_W:0]       w_sum [NUM_COINS];
  logic [NUM_COINS-1:0] w_avail;
  logic                 w_found;
  logic [IDX_W-1:0]     w_sel_idx;
  logic [AMT_W-1:0]     w_coin_val;
  logic                 w_handshake;

  change_coin_select #(
    .AMT_W     (AMT_W),
    .NUM_COINS (NUM_COINS),
    .IDX_W     (IDX_W)
  ) u_coin_select (
    .i_rem         (r_rem),
    .i_coin_values (COIN_VALUES),
    .i_avail       (w_avail),
    .o_found       (w_found),
    .o_idx         (w_sel_idx)
  );

  assign w_handshake = (r_state == StDispense) && coin_ready;
  assign w_coin_val  = COIN_VALUES[r_coin_idx*AMT_W +: AMT_W];

  always_comb begin
    w_state_next       = r_state;
    w_rem_next         = r_rem;
    w_paid_acc_next    = r_paid_acc;
    w_shortfall_next   = r_shortfall;
    w_paid_next        = r_paid;
    w_coin_valid_next  = r_coin_valid;
    w_coin_onehot_next = r_coin_onehot;
    w_coin_idx_next    = r_coin_idx;
    w_done_next        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_rem_next      = req_amount;
          w_paid_acc_next = '0;
          w_state_next    = StSelect;
        end
      end
      StSelect: begin
        // rem==0 never finds a coin (all values nonzero), so it lands here too.
        if (w_found) begin
          w_coin_onehot_next = NUM_COINS'(1) << w_sel_idx;
          w_coin_valid_next  = 1'b1;
          w_coin_idx_next    = w_sel_idx;
          w_state_next       = StDispense;
        end else begin
          w_shortfall_next = r_rem;
          w_paid_next      = r_paid_acc;
          w_done_next      = 1'b1;
          w_state_next     = StDone;
        end
      end
      StDispense: begin
        if (coin_ready) begin
          w_rem_next         = r_rem - w_coin_val;
          w_paid_acc_next    = r_paid_acc + w_coin_val;
          w_coin_valid_next  = 1'b0;
          w_coin_onehot_next = '0;
          w_state_next       = StSelect;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Refill and dispense on the same slot combine before saturating.
  always_comb begin
    for (int i = 0; i < NUM_COINS; i++) begin
      w_sum[i] = {1'b0, r_inv[i]};
      if (refill_en && (refill_idx == IDX_W'(i))) begin
        w_sum[i] = w_sum[i] + {1'b0, refill_cnt};
      end
      if (w_handshake && (r_coin_idx == IDX_W'(i))) begin
        w_sum[i] = w_sum[i] - (CNT_W+1)'(1);
      end
      w_inv_next[i] = w_sum[i][CNT_W] ? '1 : w_sum[i][CNT_W-1:0];
      w_avail[i]    = (r_inv[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_rem         <= '0;
      r_paid_acc    <= '0;
      r_shortfall   <= '0;
      r_paid        <= '0;
      r_coin_valid  <= 1'b0;
      r_coin_onehot <= '0;
      r_coin_idx    <= '0;
      r_done        <= 1'b0;
      for (int i = 0; i < NUM_COINS; i++) r_inv[i] <= '0;
    end else begin
      r_state       <= w_state_next;
      r_rem         <= w_rem_next;
      r_paid_acc    <= w_paid_acc_next;
      r_shortfall   <= w_shortfall_next;
      r_paid        <= w_paid_next;
      r_coin_valid  <= w_coin_valid_next;
      r_coin_onehot <= w_coin_onehot_next;
      r_coin_idx    <= w_coin_idx_next;
      r_done        <= w_done_next;
      for (int i = 0; i < NUM_COINS; i++) r_inv[i] <= w_inv_next[i];
    end
  end

  assign req_ready   = (r_state == StIdle);
  assign coin_valid  = r_coin_valid;
  assign coin_onehot = r_coin_onehot;
  assign done        = r_done;
  assign shortfall   = r_shortfall;
  assign paid        = r_paid;
  assign inv_empty   = ~w_avail;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: directed cases plus randomized
// requests/refills checked against a greedy change-making model.
module tb_change_dispenser;

  localparam int NC = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [8:0] req_amount = '0;
  logic       coin_valid;
  logic       coin_ready;
  logic [4:0] coin_onehot;
  logic       refill_en = 1'b0;
  logic [2:0] refill_idx = '0;
  logic [3:0] refill_cnt = '0;
  logic [4:0] inv_empty;
  logic       done;
  logic [8:0] shortfall;
  logic [8:0] paid;

  logic cr_fixed = 1'b1;
  logic cr_rand = 1'b1;
  logic rand_mode = 1'b0;
  assign coin_ready = rand_mode ? cr_rand : cr_fixed;

  change_dispenser u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_amount  (req_amount),
    .coin_valid  (coin_valid),
    .coin_ready  (coin_ready),
    .coin_onehot (coin_onehot),
    .refill_en   (refill_en),
    .refill_idx  (refill_idx),
    .refill_cnt  (refill_cnt),
    .inv_empty   (inv_empty),
    .done        (done),
    .shortfall   (shortfall),
    .paid        (paid)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_done;
    logic [4:0] oh;
    int         paid;
    int         sf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   mdl_inv[NC];
  int   vals[NC] = '{5, 10, 25, 50, 100};
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   prev_stall = 1'b0;
  logic [4:0] prev_oh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event with no expected entry (t=%0t)", name, $time);
  endtask

  // Greedy model: largest in-stock coin not exceeding what is still owed.
  function automatic void model_txn(input int amt);
    int   rem = amt;
    int   acc = 0;
    int   best;
    exp_t e;
    forever begin
      best = -1;
      for (int i = 0; i < NC; i++) if (mdl_inv[i] > 0 && vals[i] <= rem) best = i;
      if (best < 0) break;
      e.is_done = 1'b0; e.oh = 5'(1 << best); e.paid = 0; e.sf = 0;
      sb.push_back(e);
      rem -= vals[best];
      acc += vals[best];
      mdl_inv[best]--;
    end
    e.is_done = 1'b1; e.oh = '0; e.paid = acc; e.sf = rem;
    sb.push_back(e);
  endfunction

  function automatic logic [4:0] model_empty();
    logic [4:0] v;
    for (int i = 0; i < NC; i++) v[i] = (mdl_inv[i] == 0);
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset_n || !mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(coin_valid), 32'd1);
        check("stall_onehot", 32'(coin_onehot), 32'(prev_oh));
      end
      if (coin_valid && coin_ready) begin
        if (sb.size() == 0) fail_now("unexpected_coin");
        else begin
          mon_e = sb.pop_front();
          check("coin_not_done", 32'(mon_e.is_done), 32'd0);
          check("coin_onehot", 32'(coin_onehot), 32'(mon_e.oh));
        end
      end
      if (done) begin
        if (sb.size() == 0) fail_now("unexpected_done");
        else begin
          mon_e = sb.pop_front();
          check("done_expected", 32'(mon_e.is_done), 32'd1);
          check("paid", 32'(paid), 32'(mon_e.paid));
          check("shortfall", 32'(shortfall), 32'(mon_e.sf));
        end
      end
      prev_stall = coin_valid && !coin_ready;
      prev_oh    = coin_onehot;
    end
  end

  always @(posedge clk) begin
    #1;
    cr_rand = ($urandom_range(0, 3) != 0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_refill(input int idx, input int cnt);
    refill_en  = 1'b1;
    refill_idx = 3'(idx);
    refill_cnt = 4'(cnt);
    if (idx < NC) mdl_inv[idx] = (mdl_inv[idx] + cnt > 15) ? 15 : mdl_inv[idx] + cnt;
    cyc();
    refill_en = 1'b0;
  endtask

  task automatic issue(input int amt);
    int n = 0;
    while (!req_ready && n < 500) begin cyc(); n++; end
    check("req_ready_before_issue", 32'(req_ready), 32'd1);
    model_txn(amt);
    req_valid  = 1'b1;
    req_amount = 9'(amt);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || !req_ready) && n < 3000) begin cyc(); n++; end
    check("txn_complete_pending", 32'(sb.size()), 32'd0);
    check("inv_empty", 32'(inv_empty), 32'(model_empty()));
  endtask

  task automatic wait_coin_valid();
    int n = 0;
    while (!coin_valid && n < 50) begin cyc(); n++; end
    check("coin_valid_arrives", 32'(coin_valid), 32'd1);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    sb.delete();
    for (int i = 0; i < NC; i++) mdl_inv[i] = 0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NC; i++) mdl_inv[i] = 0;
    #12;
    check("rst_coin_valid", 32'(coin_valid), 32'd0);
    check("rst_coin_onehot", 32'(coin_onehot), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_paid", 32'(paid), 32'd0);
    check("rst_shortfall", 32'(shortfall), 32'd0);
    check("rst_inv_empty", 32'(inv_empty), 32'h1f);
    cyc();
    reset_n = 1'b1;
    mon_en  = 1'b1;
    cyc();
    check("req_ready_after_reset", 32'(req_ready), 32'd1);

    // Full inventory: dollar, half, quarter, dime.
    for (int i = 0; i < NC; i++) do_refill(i, 15);
    check("inv_full", 32'(inv_empty), 32'd0);
    issue(185);
    wait_idle();

    // No dollars: three halves, quarter, dime.
    apply_reset();
    for (int i = 0; i < 4; i++) do_refill(i, 15);
    issue(185);
    wait_idle();

    // Two nickels only: 17 leaves 7 unpaid; then a zero request.
    apply_reset();
    do_refill(0, 2);
    issue(17);
    wait_idle();
    issue(0);
    wait_idle();

    // Five-cycle stall on the first coin.
    apply_reset();
    for (int i = 0; i < NC; i++) do_refill(i, 15);
    cr_fixed = 1'b0;
    issue(100);
    wait_coin_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold_valid", 32'(coin_valid), 32'd1);
      check("stall_hold_dollar", 32'(coin_onehot), 32'h10);
    end
    cyc();
    cr_fixed = 1'b1;
    wait_idle();
    issue(511);
    wait_idle();

    // Refill coinciding with a nickel handshake, then drain to confirm.
    apply_reset();
    do_refill(0, 1);
    cr_fixed = 1'b0;
    issue(5);
    wait_coin_valid();
    cr_fixed = 1'b1;
    do_refill(0, 3);
    wait_idle();
    issue(20);
    wait_idle();

    // Saturation: 14 + 15 caps at 15; 80 cents then pays only 75.
    apply_reset();
    do_refill(0, 14);
    do_refill(0, 15);
    issue(80);
    wait_idle();

    // Out-of-range refill index is ignored.
    do_refill(6, 9);
    check("ignored_refill", 32'(inv_empty), 32'h1f);

    // Async reset in the middle of a dispense.
    for (int i = 0; i < NC; i++) do_refill(i, 15);
    cr_fixed = 1'b0;
    issue(50);
    wait_coin_valid();
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_coin_valid", 32'(coin_valid), 32'd0);
    check("mid_rst_onehot", 32'(coin_onehot), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    sb.delete();
    for (int i = 0; i < NC; i++) mdl_inv[i] = 0;
    cr_fixed = 1'b1;
    cyc();
    cyc();
    reset_n = 1'b1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_inv_empty", 32'(inv_empty), 32'h1f);
    repeat (4) cyc();

    // Randomized requests with random refills and random coin_ready.
    rand_mode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      int nref = $urandom_range(0, 4);
      for (int r = 0; r < nref; r++) do_refill($urandom_range(0, 7), $urandom_range(0, 15));
      issue($urandom_range(0, 400));
      wait_idle();
    end
    rand_mode = 1'b0;
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
